sevenseg_scan: RTL and testbench



---
 rtl/sevenseg_scan_pkg.sv | 10 +
 rtl/sevenseg_scan_sevenseg.sv | 17 +
 rtl/sevenseg_scan.sv | 105 ++++++++++
 tb/tb_sevenseg_scan.sv | 135 +++++++++++++
 4 files changed

// File: rtl/sevenseg_scan_pkg.sv
// sevenseg_scan_pkg: scan FSM state type and digit-select helper.
package sevenseg_scan_pkg;
   typedef enum logic [0:0] {SCAN_SHOW, SCAN_BLANK} t_scan_state;
   localparam int MAX_DIGITS = 8;
   function automatic logic [MAX_DIGITS-1:0] onehot_sel(input logic [2:0] idx, input logic active_low);
      logic [MAX_DIGITS-1:0] oh;
      oh = MAX_DIGITS'(1) << idx;
      return active_low ? ~oh : oh;
   endfunction
endpackage

// File: rtl/sevenseg_scan_sevenseg.sv
// sevenseg: hex nibble to seven-segment decoder, bit 6 = segment a when not inverse_numbering.
module sevenseg #(
   parameter bit zero_is_on        = 1'b0,
   parameter bit inverse_numbering = 1'b0
) (
   input  logic [3:0] in_nibble,
   output logic [6:0] out_leds
);
   localparam logic [6:0] SEG [16] = '{
      7'h7e, 7'h30, 7'h6d, 7'h79, 7'h33, 7'h5b, 7'h5f, 7'h70,
      7'h7f, 7'h7b, 7'h77, 7'h1f, 7'h4e, 7'h3d, 7'h4f, 7'h47};
   logic [6:0] raw;
   logic [6:0] rev;
   assign raw = SEG[in_nibble];
   assign rev = {<<{raw}};
   assign out_leds = (inverse_numbering ? rev : raw) ^ {7{zero_is_on}};
endmodule

// File: rtl/sevenseg_scan.sv
// sevenseg_scan: multiplexed seven-segment scanner with frame-aligned value commit.
// Define SEVENSEG_SCAN_LZB_EN to enable leading-zero blanking.
module sevenseg_scan
   import sevenseg_scan_pkg::*;
#(
   parameter int num_digits        = 4,
   parameter int digit_cycles      = 50000,
   parameter int blank_cycles      = 500,
   parameter bit zero_is_on        = 1'b0,
   parameter bit sel_zero_is_on    = 1'b1,
   parameter bit inverse_numbering = 1'b0
) (
   input  logic                          in_clk,
   input  logic                          in_rst,
   input  logic [4*num_digits-1:0]       in_value,
   input  logic                          in_update,
   output logic                          out_ack,
   output logic [6:0]                    out_leds,
   output logic [num_digits-1:0]         out_sel,
   output logic [$clog2(num_digits)-1:0] out_digit_idx
);
   localparam int IW = $clog2(num_digits);
   localparam int DW = 4 * num_digits;
   localparam int CMAX = digit_cycles > blank_cycles ? digit_cycles : blank_cycles;
   localparam int CW = CMAX > 1 ? $clog2(CMAX) : 1;
   localparam logic [6:0] LEDS_OFF = zero_is_on ? 7'h7f : 7'h00;
   localparam logic [num_digits-1:0] SEL_OFF = sel_zero_is_on ? '1 : '0;

   t_scan_state           state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [IW-1:0]         idx_q, idx_d, digit_idx_q, digit_idx_d;
   logic [DW-1:0]         display_q, display_d, staging_q, staging_d;
   logic                  pending_q, pending_d, ack_q, ack_d;
   logic [6:0]            leds_q, leds_d, dec_leds;
   logic [num_digits-1:0] sel_q, sel_d;
   logic                  frame_start, lzb;

   sevenseg #(.zero_is_on(zero_is_on), .inverse_numbering(inverse_numbering)) u_dec (
      .in_nibble(display_q[{idx_q, 2'b00} +: 4]),
      .out_leds (dec_leds)
   );

`ifdef SEVENSEG_SCAN_LZB_EN
   assign lzb = (idx_q != '0) && ((display_q >> {idx_q, 2'b00}) == '0);
`else
   assign lzb = 1'b0;
`endif

   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         state_q     <= SCAN_BLANK;
         cnt_q       <= CW'(blank_cycles - 1);
         idx_q       <= IW'(num_digits - 1);
         display_q   <= '0;
         staging_q   <= '0;
         pending_q   <= 1'b0;
         ack_q       <= 1'b0;
         leds_q      <= LEDS_OFF;
         sel_q       <= SEL_OFF;
         digit_idx_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         display_q   <= display_d;
         staging_q   <= staging_d;
         pending_q   <= pending_d;
         ack_q       <= ack_d;
         leds_q      <= leds_d;
         sel_q       <= sel_d;
         digit_idx_q <= digit_idx_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q - CW'(1);
      idx_d       = idx_q;
      frame_start = 1'b0;
      if (cnt_q == '0) begin
         state_d = state_q == SCAN_SHOW ? SCAN_BLANK : SCAN_SHOW;
         cnt_d   = state_q == SCAN_SHOW ? CW'(blank_cycles - 1) : CW'(digit_cycles - 1);
         if (state_q == SCAN_BLANK) begin
            idx_d       = idx_q == IW'(num_digits - 1) ? '0 : idx_q + IW'(1);
            frame_start = idx_q == IW'(num_digits - 1);
         end
      end
   end

   // A strobe coinciding with a commit lands in staging and stays pending for the next frame.
   always_comb begin
      staging_d   = in_update ? in_value : staging_q;
      pending_d   = in_update | (pending_q & ~frame_start);
      ack_d       = frame_start & pending_q;
      display_d   = ack_d ? staging_q : display_q;
      leds_d      = (state_q == SCAN_SHOW && !lzb) ? dec_leds : LEDS_OFF;
      sel_d       = state_q == SCAN_SHOW ? num_digits'(onehot_sel(3'(idx_q), sel_zero_is_on)) : SEL_OFF;
      digit_idx_d = idx_q;
   end

   assign out_ack       = ack_q;
   assign out_leds      = leds_q;
   assign out_sel       = sel_q;
   assign out_digit_idx = digit_idx_q;
endmodule

// File: tb/tb_sevenseg_scan.sv
// tb_sevenseg_scan: directed and random checks of sevenseg_scan against a time-based frame model.
module tb_sevenseg_scan;
   localparam int ND = 4, DC = 4, BC = 2, SLOT = DC + BC, FRAME = ND * SLOT;

   logic        clk = 1'b0, in_rst = 1'b1, in_update = 1'b0, out_ack;
   logic [15:0] in_value = '0;
   logic [6:0]  out_leds;
   logic [3:0]  out_sel;
   logic [1:0]  out_digit_idx;

   logic [6:0]  seg [16] = '{7'h7e, 7'h30, 7'h6d, 7'h79, 7'h33, 7'h5b, 7'h5f, 7'h70,
                            7'h7f, 7'h7b, 7'h77, 7'h1f, 7'h4e, 7'h3d, 7'h4f, 7'h47};
   int          n_cmp = 0, n_err = 0, n_ack = 0, p = 0;
   logic [15:0] disp = '0, staged = '0;
   bit          pend = 1'b0;
   logic [6:0]  e_leds;
   logic [3:0]  e_sel;
   logic [1:0]  e_idx;
   logic        e_ack;

   sevenseg_scan #(.num_digits(ND), .digit_cycles(DC), .blank_cycles(BC),
                   .zero_is_on(1'b0), .sel_zero_is_on(1'b1), .inverse_numbering(1'b0)) dut (
      .in_clk(clk), .in_rst(in_rst), .in_value(in_value), .in_update(in_update),
      .out_ack(out_ack), .out_leds(out_leds), .out_sel(out_sel), .out_digit_idx(out_digit_idx));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h (edge %0d)", tag, got, exp, p);
      end
   endtask

   // Outputs after edge p+1 reflect the scan position reached after p edges since reset.
   task automatic cyc(input bit upd, input logic [15:0] val);
      int  q, d;
      bit  show, lz, fs;
      in_update = upd;
      in_value  = val;
      @(posedge clk);
      show = 1'b0;
      d    = ND - 1;
      if (p >= BC) begin
         q    = (p - BC) % FRAME;
         d    = q / SLOT;
         show = (q % SLOT) < DC;
      end
`ifdef SEVENSEG_SCAN_LZB_EN
      lz = d > 0 && (disp >> (4 * d)) == 0;
`else
      lz = 1'b0;
`endif
      e_sel  = show ? ~(4'b0001 << d) : 4'hf;
      e_leds = (show && !lz) ? seg[disp[4*d +: 4]] : 7'h00;
      e_idx  = 2'(d);
      fs     = p >= BC - 1 && (p - (BC - 1)) % FRAME == 0;
      e_ack  = fs && pend;
      if (e_ack) disp = staged;
      pend = upd || (pend && !fs);
      if (upd) staged = val;
      p++;
      @(negedge clk);
      in_update = 1'b0;
      if (out_ack === 1'b1) n_ack++;
      chk("sel", 32'(out_sel), 32'(e_sel));
      chk("leds", 32'(out_leds), 32'(e_leds));
      chk("ack", 32'(out_ack), 32'(e_ack));
      chk("digit_idx", 32'(out_digit_idx), 32'(e_idx));
   endtask

   task automatic rst_pulse();
      in_rst    = 1'b1;
      in_update = 1'b0;
      @(posedge clk);
      p = 0; disp = '0; staged = '0; pend = 1'b0;
      @(negedge clk);
      chk("rst_sel", 32'(out_sel), 32'hf);
      chk("rst_leds", 32'(out_leds), 32'h0);
      chk("rst_ack", 32'(out_ack), 32'h0);
      chk("rst_idx", 32'(out_digit_idx), 32'h0);
      in_rst = 1'b0;
   endtask

   task automatic to_commit_edge();
      for (int i = 0; i < 2 * FRAME && !(p >= BC - 1 && (p - (BC - 1)) % FRAME == 0); i++) cyc(1'b0, '0);
   endtask

   initial begin
      @(negedge clk);
      rst_pulse();
      cyc(1'b0, '0);
      cyc(1'b0, '0);
      cyc(1'b0, '0);
      chk("first_show_sel", 32'(out_sel), 32'he);
      chk("first_show_leds", 32'(out_leds), 32'h7e);
      repeat (10) cyc(1'b0, '0);
      n_ack = 0;
      cyc(1'b1, 16'h1234);
      repeat (2 * FRAME) cyc(1'b0, '0);
      chk("ack_cnt_1234", n_ack, 1);
      to_commit_edge();
      cyc(1'b0, '0);
      n_ack = 0;
      cyc(1'b1, 16'hAAAA);
      repeat (5) cyc(1'b0, '0);
      cyc(1'b1, 16'h00F0);
      repeat (2 * FRAME) cyc(1'b0, '0);
      chk("ack_cnt_00f0", n_ack, 1);
      to_commit_edge();
      cyc(1'b0, '0);
      n_ack = 0;
      cyc(1'b1, 16'h1111);
      to_commit_edge();
      cyc(1'b1, 16'hBEEF);
      repeat (FRAME / 2) cyc(1'b0, '0);
      chk("disp_1111", 32'(out_leds | 7'(out_sel == 4'hf ? 7'h30 : 7'h00)), 32'h30);
      repeat (2 * FRAME) cyc(1'b0, '0);
      chk("ack_cnt_beef", n_ack, 2);
      to_commit_edge();
      cyc(1'b0, '0);
      cyc(1'b1, 16'h5555);
      for (int i = 0; i < 2 * FRAME && !(p >= BC && (p - BC) % FRAME == 2 * SLOT + 1); i++) cyc(1'b0, '0);
      rst_pulse();
      n_ack = 0;
      repeat (2 * FRAME) cyc(1'b0, '0);
      chk("ack_cnt_after_rst", n_ack, 0);
      cyc(1'b1, 16'h0050);
      repeat (3 * FRAME) cyc(1'b0, '0);
      repeat (400) cyc($urandom_range(0, 9) == 0, 16'($urandom));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
